// File: rtl/button_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : button_event_decoder
// Description : Turns a debounced button level into one-cycle press, release,
//               short-click, double-click and long-press events.
//               Optional feature macro: BUTTON_DOUBLE_CLICK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module button_event_decoder #(
    parameter int LONG_CNT = 16,
    parameter int DBL_GAP  = 8,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_deb,
    output logic held,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_click,
    output logic double_click,
    output logic long_press
);

    if ((LONG_CNT < 2) || (DBL_GAP < 2) ||
        ((2 ** CNT_W) <= LONG_CNT) || ((2 ** CNT_W) <= DBL_GAP)) begin : g_bad_params
        $error("button_event_decoder: illegal LONG_CNT/DBL_GAP/CNT_W combination");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRESS1 = 3'd1,
        S_LONG   = 3'd2
`ifdef BUTTON_DOUBLE_CLICK_EN
        ,
        S_WAIT2  = 3'd3,
        S_PRESS2 = 3'd4
`endif
    } state_t;

    localparam logic [CNT_W-1:0] c_LONG_LAST = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};
`ifdef BUTTON_DOUBLE_CLICK_EN
    localparam logic [CNT_W-1:0] c_GAP_LAST  = CNT_W'(DBL_GAP - 1);
`endif

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pb_q;
    logic             r_pb_q_d;
    logic             w_rise;
    logic             w_fall;
    logic             w_press_nxt;
    logic             w_release_nxt;
    logic             w_short_nxt;
    logic             w_double_nxt;
    logic             w_long_nxt;
    logic             r_press;
    logic             r_release;
    logic             r_short;
    logic             r_double;
    logic             r_long;

    assign w_rise = r_pb_q & ~r_pb_q_d;
    assign w_fall = ~r_pb_q & r_pb_q_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pb_q   <= 1'b0;
            r_pb_q_d <= 1'b0;
        end else begin
            r_pb_q   <= pb_deb;
            r_pb_q_d <= r_pb_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counter restarts on every state change so each state times itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_cnt <= '0;
        end else if (r_cnt != c_CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Edge checks come before threshold checks so the edge wins on a tie.
    always_comb begin
        w_state_nxt   = r_state;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_short_nxt   = 1'b0;
        w_double_nxt  = 1'b0;
        w_long_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = S_PRESS1;
                    w_press_nxt = 1'b1;
                end
            end
            S_PRESS1: begin
                if (w_fall) begin
                    w_release_nxt = 1'b1;
`ifdef BUTTON_DOUBLE_CLICK_EN
                    w_state_nxt   = S_WAIT2;
`else
                    w_state_nxt   = S_IDLE;
                    w_short_nxt   = 1'b1;
`endif
                end else if (r_cnt == c_LONG_LAST) begin
                    w_state_nxt = S_LONG;
                    w_long_nxt  = 1'b1;
                end
            end
            S_LONG: begin
                if (w_fall) begin
                    w_state_nxt   = S_IDLE;
                    w_release_nxt = 1'b1;
                end
            end
`ifdef BUTTON_DOUBLE_CLICK_EN
            S_WAIT2: begin
                if (w_rise) begin
                    w_state_nxt = S_PRESS2;
                    w_press_nxt = 1'b1;
                end else if (r_cnt == c_GAP_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_short_nxt = 1'b1;
                end
            end
            S_PRESS2: begin
                if (w_fall) begin
                    w_state_nxt   = S_IDLE;
                    w_release_nxt = 1'b1;
                    w_double_nxt  = 1'b1;
                end else if (r_cnt == c_LONG_LAST) begin
                    w_state_nxt = S_LONG;
                    w_long_nxt  = 1'b1;
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_short   <= 1'b0;
            r_double  <= 1'b0;
            r_long    <= 1'b0;
        end else begin
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            r_short   <= w_short_nxt;
            r_double  <= w_double_nxt;
            r_long    <= w_long_nxt;
        end
    end

    assign held          = r_pb_q;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign short_click   = r_short;
    assign double_click  = r_double;
    assign long_press    = r_long;

endmodule
`default_nettype wire

// File: tb/tb_button_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_event_decoder
// Description : Scoreboard bench for button_event_decoder; expected events are
//               queued with their cycle numbers and matched by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_event_decoder;

    localparam int LONG_CNT = 16;
    localparam int DBL_GAP  = 8;

    localparam logic [4:0] c_EV_P = 5'b10000;
    localparam logic [4:0] c_EV_R = 5'b01000;
    localparam logic [4:0] c_EV_S = 5'b00100;
    localparam logic [4:0] c_EV_D = 5'b00010;
    localparam logic [4:0] c_EV_L = 5'b00001;

    logic clk = 1'b0;
    logic rst;
    logic pb_deb;
    logic held;
    logic press_pulse;
    logic release_pulse;
    logic short_click;
    logic double_click;
    logic long_press;

    typedef struct {
        int         cyc;
        logic [4:0] ev;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    button_event_decoder #(
        .LONG_CNT (LONG_CNT),
        .DBL_GAP  (DBL_GAP),
        .CNT_W    (8)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .pb_deb        (pb_deb),
        .held          (held),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .short_click   (short_click),
        .double_click  (double_click),
        .long_press    (long_press)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic void push(int c, logic [4:0] ev);
        exp_t e;
        e.cyc = c;
        e.ev  = ev;
        q.push_back(e);
    endfunction

    function automatic void chk(string name, int got, int req);
        n_cmp++;
        if (got != req) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d (cyc %0d)", name, got, req, cyc);
        end
    endfunction

    // Button goes high at cycle k for h cycles; events measured from there.
    function automatic void expect_click(int k, int h);
        int m;
        m = k + h;
        push(k + 2, c_EV_P);
        if (h > LONG_CNT) begin
            push(k + 2 + LONG_CNT, c_EV_L);
            push(m + 2, c_EV_R);
        end else begin
`ifdef BUTTON_DOUBLE_CLICK_EN
            push(m + 2, c_EV_R);
            push(m + 2 + DBL_GAP, c_EV_S);
`else
            push(m + 2, c_EV_R | c_EV_S);
`endif
        end
    endfunction

    task automatic drive(logic v, int n);
        pb_deb = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic click(int h, int idle);
        expect_click(cyc, h);
        drive(1'b1, h);
        drive(1'b0, idle);
    endtask

    task automatic dbl(int h1, int l, int h2, int idle);
        int k, m, k2, m2;
        k  = cyc;
        m  = k + h1;
        k2 = m + l;
        m2 = k2 + h2;
`ifdef BUTTON_DOUBLE_CLICK_EN
        push(k + 2, c_EV_P);
        push(m + 2, c_EV_R);
        if (l <= DBL_GAP) begin
            push(k2 + 2, c_EV_P);
            push(m2 + 2, c_EV_R | c_EV_D);
        end else begin
            push(m + 2 + DBL_GAP, c_EV_S);
            push(k2 + 2, c_EV_P);
            push(m2 + 2, c_EV_R);
            push(m2 + 2 + DBL_GAP, c_EV_S);
        end
`else
        expect_click(k, h1);
        expect_click(k2, h2);
`endif
        drive(1'b1, h1);
        drive(1'b0, l);
        drive(1'b1, h2);
        drive(1'b0, idle);
    endtask

    // Monitor: every cycle with any event high must match the queue head.
    initial begin
        logic [4:0] w;
        exp_t       e;
        forever begin
            @(negedge clk);
            w = {press_pulse, release_pulse, short_click, double_click, long_press};
            if (w != 5'b0) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_event: got ev=%b at cyc %0d, required none", w, cyc);
                end else begin
                    e = q.pop_front();
                    if ((e.cyc != cyc) || (e.ev != w)) begin
                        n_bad++;
                        $display("FAIL event: got ev=%b at cyc %0d, required ev=%b at cyc %0d",
                                 w, cyc, e.ev, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        rst    = 1'b1;
        pb_deb = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("reset_outputs",
                int'({held, press_pulse, release_pulse, short_click, double_click, long_press}), 0);
        end
        // Button held through reset: a press follows reset release.
        expect_click(cyc, 5);
        rst = 1'b0;
        @(negedge clk);
        chk("held_after_reset", int'(held), 1);
        drive(1'b1, 4);
        drive(1'b0, 20);
        chk("held_released", int'(held), 0);

        click(5, 20);
        dbl(4, 3, 4, 20);
        click(40, 20);
        click(LONG_CNT, 20);
        click(LONG_CNT + 1, 20);
        click(1, 20);
        dbl(4, DBL_GAP, 4, 20);
        dbl(4, DBL_GAP + 1, 4, 20);
        dbl(5, 3, 5, 20);

        // Reset mid-gesture discards it; still-held button re-presses.
        push(cyc + 2, c_EV_P);
        drive(1'b1, 6);
        rst = 1'b1;
        drive(1'b1, 3);
        chk("held_in_reset", int'(held), 0);
        expect_click(cyc, 5);
        rst = 1'b0;
        drive(1'b1, 5);
        drive(1'b0, 25);

        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
